// File: rtl/serial_add_if.sv
// serial_add_if: start/operand/result bundle for the bit-serial adder
interface serial_add_if #(parameter int WIDTH = 3);
  logic start;
  logic sub;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic cin;
  logic busy;
  logic done;
  logic [WIDTH-1:0] sum_out;
  logic cout;
  logic ovf;
  modport master (output start, sub, a_in, b_in, cin, input busy, done, sum_out, cout, ovf);
  modport slave (input start, sub, a_in, b_in, cin, output busy, done, sum_out, cout, ovf);
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer sharing one full_adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 3
) (
  input logic clk,
  input logic rst,
  serial_add_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, sr_w;
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
  logic fa_s, fa_co, accept, run, last;
  full_adder u_fa (.a(a_q[idx_q]), .b(b_q[idx_q]), .ci(c_q), .s(fa_s), .co(fa_co));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sr_q    <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sr_q    <= sr_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  always_comb begin
    accept  = (state_q == IDLE) && bus.start;
    run     = (state_q == RUN);
    last    = (idx_q == IDX_W'(WIDTH - 1));
    state_d = accept ? RUN : (run && last) ? DONE : (state_q == DONE) ? IDLE : state_q;
  end
  // The SR holds the first WIDTH-1 result bits; the final sum bit completes it on the last edge
  always_comb begin
    sr_w   = {fa_s, sr_q};
    a_d    = accept ? bus.a_in : a_q;
    b_d    = accept ? bus.b_in ^ {WIDTH{bus.sub}} : b_q;
    c_d    = accept ? (bus.sub | bus.cin) : run ? fa_co : c_q;
    idx_d  = accept ? '0 : run ? idx_q + IDX_W'(1) : idx_q;
    sr_d   = run ? sr_w[WIDTH-1:1] : sr_q;
    sum_d  = (run && last) ? sr_w : sum_q;
    cout_d = (run && last) ? fa_co : cout_q;
    ovf_d  = (run && last) ? (c_q ^ fa_co) : ovf_q;
  end
  always_comb begin
    bus.busy    = (state_q == RUN);
    bus.done    = (state_q == DONE);
    bus.sum_out = sum_q;
    bus.cout    = cout_q;
    bus.ovf     = ovf_q;
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed scoreboard bench for the bit-serial adder
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  serial_add_if #(.WIDTH(3)) bi ();
  serial_add_ctrl #(.WIDTH(3)) dut (.clk(clk), .rst(rst), .bus(bi.slave));
  typedef struct packed {logic [2:0] s; logic c; logic o;} res_t;
  res_t sb[$];
  int errors = 0, checks = 0, n_done = 0, cyc = 0, last_done = 0, nd = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (bi.done === 1'b1) n_done++;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  function automatic res_t model(logic [2:0] a, logic [2:0] b, logic ci, logic op_sub);
    logic [2:0] bb;
    logic c;
    logic [3:0] full;
    logic [2:0] lo;
    res_t r;
    bb = op_sub ? ~b : b;
    c = op_sub | ci;
    full = {1'b0, a} + {1'b0, bb} + {3'b0, c};
    lo = {1'b0, a[1:0]} + {1'b0, bb[1:0]} + {2'b0, c};
    r.s = full[2:0];
    r.c = full[3];
    r.o = lo[2] ^ full[3];
    return r;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic start_op(string tag, logic [2:0] a, logic [2:0] b, logic ci, logic op_sub);
    @(negedge clk);
    bi.a_in = a; bi.b_in = b; bi.cin = ci; bi.sub = op_sub; bi.start = 1'b1;
    @(posedge clk);
    sb.push_back(model(a, b, ci, op_sub));
    #1;
    chk({tag, "_busy"}, 32'(bi.busy), 1);
    @(negedge clk);
    bi.start = 1'b0;
  endtask
  task automatic check_result(string tag);
    res_t e;
    chk({tag, "_sb"}, 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_sum"}, 32'(bi.sum_out), 32'(e.s));
      chk({tag, "_cout"}, 32'(bi.cout), 32'(e.c));
      chk({tag, "_ovf"}, 32'(bi.ovf), 32'(e.o));
    end
  endtask
  task automatic finish_op(string tag, int lat);
    int n = 0;
    while (bi.done !== 1'b1 && n < 12) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_busy_done"}, 32'(bi.busy), 0);
    check_result(tag);
    @(posedge clk);
    #1;
    chk({tag, "_done_1cyc"}, 32'(bi.done), 0);
  endtask
  initial begin
    logic [2:0] ta[3] = '{3'd7, 3'd4, 3'd2};
    logic [2:0] tb[3] = '{3'd7, 3'd4, 3'd6};
    logic tc[3] = '{1'b1, 1'b0, 1'b0};
    logic ts[3] = '{1'b0, 1'b0, 1'b1};
    bi.start = 1'b0; bi.sub = 1'b0; bi.a_in = '0; bi.b_in = '0; bi.cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bi.busy), 0);
    chk("rst_done", 32'(bi.done), 0);
    chk("rst_sum", 32'(bi.sum_out), 0);
    chk("rst_cout", 32'(bi.cout), 0);
    chk("rst_ovf", 32'(bi.ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    start_op("t1", 3'd3, 3'd5, 1'b0, 1'b0);
    finish_op("t1", 3);
    start_op("t2", 3'd3, 3'd0, 1'b1, 1'b0);
    finish_op("t2", 3);
    start_op("t3a", 3'd5, 3'd3, 1'b0, 1'b1);
    finish_op("t3a", 3);
    start_op("t3b", 3'd3, 3'd5, 1'b0, 1'b1);
    finish_op("t3b", 3);
    start_op("t3c", 3'd5, 3'd3, 1'b1, 1'b1);
    finish_op("t3c", 3);
    nd = n_done;
    start_op("t4", 3'd1, 3'd2, 1'b0, 1'b0);
    bi.a_in = 3'd7; bi.b_in = 3'd7; bi.sub = 1'b1; bi.cin = 1'b1; bi.start = 1'b1;
    @(negedge clk);
    bi.start = 1'b0;
    finish_op("t4", 2);
    repeat (6) @(posedge clk);
    #1;
    chk("t4_one_done", 32'(n_done - nd), 1);
    chk("t4_not_queued", 32'(bi.busy), 0);
    nd = n_done;
    start_op("t5", 3'd6, 3'd1, 1'b0, 1'b0);
    void'(sb.pop_back());
    @(posedge clk);
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("t5_busy", 32'(bi.busy), 0);
    chk("t5_sum", 32'(bi.sum_out), 0);
    chk("t5_cout", 32'(bi.cout), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("t5_no_done", 32'(n_done - nd), 0);
    start_op("t5b", 3'd6, 3'd1, 1'b0, 1'b0);
    finish_op("t5b", 3);
    @(negedge clk);
    bi.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bi.a_in = ta[k]; bi.b_in = tb[k]; bi.cin = tc[k]; bi.sub = ts[k];
      @(posedge clk);
      sb.push_back(model(ta[k], tb[k], tc[k], ts[k]));
      #1;
      chk("t6_busy_e0", 32'(bi.busy), 1);
      repeat (2) begin
        @(posedge clk);
        #1;
        chk("t6_busy_run", 32'(bi.busy), 1);
        chk("t6_done_run", 32'(bi.done), 0);
      end
      @(posedge clk);
      #1;
      chk("t6_done", 32'(bi.done), 1);
      chk("t6_busy_done", 32'(bi.busy), 0);
      check_result("t6");
      if (k > 0) chk("t6_spacing", 32'(cyc - last_done), 5);
      last_done = cyc;
      bi.a_in = 3'd0; bi.b_in = 3'd0; bi.sub = ~bi.sub;
      @(posedge clk);
      #1;
      chk("t6_busy_idle", 32'(bi.busy), 0);
      chk("t6_done_idle", 32'(bi.done), 0);
      @(negedge clk);
    end
    bi.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("end_busy", 32'(bi.busy), 0);
    chk("end_sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
